// File: rtl/prim_arbiter_pkg.sv
// Shared types and bit-vector helpers for the arbiter primitives.
package prim_arbiter_pkg;

  typedef enum logic {
    ArbModeWrr  = 1'b0,
    ArbModePrio = 1'b1
  } arb_mode_e;

  // Widest request vector the helpers accept; callers zero-extend.
  localparam int MaxN = 64;

  function automatic logic [MaxN-1:0] lowest_one(input logic [MaxN-1:0] v);
    return v & (~v + MaxN'(1));
  endfunction

  function automatic int unsigned oh_index(input logic [MaxN-1:0] oh);
    int unsigned r;
    r = 0;
    for (int k = 0; k < MaxN; k++) begin
      if (oh[k]) r = r | unsigned'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/prim_arbiter_rr_pick.sv
// Round-robin leading-one pick: lowest request above the mask, else wrap to lowest request.
module prim_arbiter_rr_pick
  import prim_arbiter_pkg::*;
#(
  parameter int N    = 8,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    mask_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o
);

  logic [N-1:0] masked;
  logic [N-1:0] sel;
  logic [N-1:0] below;

  always_comb begin
    masked = req_i & mask_i;
    sel    = (|masked) ? masked : req_i;
    // below[i] = |sel[i-1:0], built as a log-depth prefix OR.
    below  = sel << 1;
    for (int l = 0; l < $clog2(N); l++) begin
      below = below | (below << (1 << l));
    end
    onehot_o = sel & ~below;
    idx_o    = IdxW'(oh_index(MaxN'(onehot_o)));
  end

endmodule

// File: rtl/prim_arbiter_wrr.sv
// N:1 weighted round-robin arbiter with strict-priority mode and stall locking.
module prim_arbiter_wrr
  import prim_arbiter_pkg::*;
#(
  parameter int N          = 8,
  parameter int DW         = 32,
  parameter int WeightW    = 4,
  parameter bit EnDataPort = 1'b1,
  parameter int IdxW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_chk_i,
  input  logic                 mode_i,
  input  logic [N*WeightW-1:0] weight_i,
  input  logic [N-1:0]         req_i,
  input  logic [DW-1:0]        data_i [N],
  output logic [N-1:0]         gnt_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 valid_o,
  output logic [DW-1:0]        data_o,
  input  logic                 ready_i
);

  // Handshake: valid_o offers the winner; a transfer happens in any cycle with
  // valid_o && ready_i. While valid_o && !ready_i the winner is locked and held.

  logic [N-1:0]       mask_q;
  logic [IdxW-1:0]    last_idx_q;
  logic [WeightW-1:0] cnt_q;
  logic               locked_q;
  logic [IdxW-1:0]    lock_idx_q;

  arb_mode_e          mode;
  logic [N-1:0]       rr_oh;
  logic [IdxW-1:0]    rr_idx;
  logic               hold_lock;
  logic               burst_cont;
  logic [IdxW-1:0]    win_idx;
  logic [N-1:0]       win_oh;
  logic [N-1:0]       win_oh_sh;
  logic [WeightW-1:0] win_w;
  logic               accept;
  logic               stall;

  assign mode = arb_mode_e'(mode_i);

  prim_arbiter_rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_pick (
    .req_i    (req_i),
    .mask_i   (mask_q),
    .onehot_o (rr_oh),
    .idx_o    (rr_idx)
  );

  always_comb begin
    valid_o    = |req_i;
    hold_lock  = locked_q && req_i[lock_idx_q];
    burst_cont = (mode == ArbModeWrr) && (cnt_q != '0) && req_i[last_idx_q];
    win_idx    = rr_idx;
    win_oh     = rr_oh;
    if (hold_lock) begin
      win_idx = lock_idx_q;
      win_oh  = N'(1) << lock_idx_q;
    end else if (burst_cont) begin
      win_idx = last_idx_q;
      win_oh  = N'(1) << last_idx_q;
    end else if (mode == ArbModePrio) begin
      win_idx = IdxW'(oh_index(lowest_one(MaxN'(req_i))));
      win_oh  = N'(1) << win_idx;
    end
    if (!valid_o) begin
      win_idx = '0;
      win_oh  = '0;
    end
    win_w     = weight_i[int'(win_idx)*WeightW +: WeightW];
    win_oh_sh = win_oh << 1;
    accept    = valid_o && ready_i;
    stall     = valid_o && !ready_i;
    gnt_o     = ready_i ? win_oh : '0;
    idx_o     = win_idx;
  end

  if (EnDataPort) begin : g_data
    assign data_o = valid_o ? data_i[win_idx] : '0;
  end else begin : g_no_data
    assign data_o = '1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q     <= '0;
      last_idx_q <= '0;
      cnt_q      <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else if (accept) begin
      locked_q <= 1'b0;
      mask_q   <= ~(win_oh_sh - N'(1));
      // A stalled-then-accepted burst beat still consumes one credit.
      if (burst_cont && (win_idx == last_idx_q)) begin
        cnt_q <= cnt_q - WeightW'(1);
      end else begin
        cnt_q      <= win_w;
        last_idx_q <= win_idx;
      end
    end else begin
      if (stall) begin
        locked_q   <= 1'b1;
        lock_idx_q <= win_idx;
      end else begin
        locked_q <= 1'b0;
      end
      if (!req_i[last_idx_q]) cnt_q <= '0;
    end
  end

`ifndef SYNTHESIS
  logic [WeightW:0]   streak_n;
  logic [IdxW-1:0]    streak_idx;
  logic [WeightW-1:0] streak_w;
  logic               others_req;

  assign others_req = |(req_i & ~win_oh);

  always_ff @(posedge clk_i) begin
    if (rst_i || !valid_o) begin
      streak_n   <= '0;
      streak_idx <= '0;
      streak_w   <= '0;
    end else if (accept) begin
      if ((mode == ArbModePrio) || !others_req) begin
        streak_n <= '0;
      end else if ((streak_n != '0) && (win_idx == streak_idx)) begin
        streak_n <= streak_n + 1'b1;
      end else begin
        streak_n   <= 1;
        streak_idx <= win_idx;
        streak_w   <= win_w;
      end
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_o));
  a_gnt_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (|gnt_o) |-> (ready_i && req_i[idx_o] && gnt_o[idx_o]));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (stall && !rst_i) |=> ((idx_o == $past(idx_o)) || !req_i[$past(idx_o)]));
  a_lock_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_chk_i && locked_q) |-> req_i[lock_idx_q]);
  a_burst_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    (accept && (mode == ArbModeWrr) && others_req && (streak_n != '0) &&
     (win_idx == streak_idx)) |-> (streak_n <= {1'b0, streak_w}));
  a_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({gnt_o, idx_o, valid_o, data_o}));
`endif

endmodule

// File: tb/tb_prim_arbiter_wrr.sv
// Directed bench for prim_arbiter_wrr (N=4): driver pushes expectations, negedge monitor checks.
module tb_prim_arbiter_wrr;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int IW = 2;
  localparam int EW = 1 + N + IW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_chk = 1'b1;
  logic          mode = 1'b0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]  req = '0;
  logic [DW-1:0] data [N];
  logic [N-1:0]  gnt;
  logic [IW-1:0] idx;
  logic          valid;
  logic [DW-1:0] dout;
  logic          ready = 1'b1;

  logic [EW-1:0] exp_q [$];
  string         name_q [$];
  int            checks = 0;
  int            passes = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_data
    assign data[k] = 32'hA000_0000 + k;
  end

  prim_arbiter_wrr #(
    .N          (N),
    .DW         (DW),
    .WeightW    (WW),
    .EnDataPort (1'b1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_chk_i (req_chk),
    .mode_i    (mode),
    .weight_i  (weight),
    .req_i     (req),
    .data_i    (data),
    .gnt_o     (gnt),
    .idx_o     (idx),
    .valid_o   (valid),
    .data_o    (dout),
    .ready_i   (ready)
  );

  // Drive one cycle of inputs and queue the hand-computed winner for it.
  task automatic step(input logic r, input logic m, input logic [N-1:0] rq,
                      input logic rdy, input int e_idx, input string nm);
    logic          ev;
    logic [N-1:0]  eg;
    logic [IW-1:0] ei;
    logic [DW-1:0] ed;
    @(posedge clk);
    #1;
    rst   = r;
    mode  = m;
    req   = rq;
    ready = rdy;
    ev = |rq;
    ei = ev ? e_idx[IW-1:0] : '0;
    eg = (ev && rdy) ? (N'(1) << ei) : '0;
    ed = ev ? (32'hA000_0000 + e_idx) : '0;
    exp_q.push_back({ev, eg, ei, ed});
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input logic [N*WW-1:0] w);
    weight = w;
    step(1'b1, 1'b0, 4'b0000, 1'b1, 0, "reset_idle");
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {valid, gnt, idx, dout};
      checks++;
      if (a === e) begin
        passes++;
      end else begin
        $display("FAIL %s: got valid=%0b gnt=%b idx=%0d data=%h, want valid=%0b gnt=%b idx=%0d data=%h",
                 nm, a[EW-1], a[EW-2 -: N], a[DW +: IW], a[DW-1:0],
                 e[EW-1], e[EW-2 -: N], e[DW +: IW], e[DW-1:0]);
      end
    end
  end

  int seq2 [10] = '{0, 1, 1, 1, 2, 3, 0, 1, 1, 1};

  initial begin
    // Reset outputs and first grant right after reset.
    do_reset(16'h0000);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 0, "reset_idle2");
    step(1'b0, 1'b0, 4'b0100, 1'b1, 2, "first_gnt");

    // Weighted order, weight[1]=2.
    do_reset(16'h0020);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b1111, 1'b1, seq2[i], "wrr_seq");

    // Stall holds port 0 while port 1 arrives.
    do_reset(16'h0000);
    step(1'b0, 1'b0, 4'b0001, 1'b0, 0, "stall_c1");
    step(1'b0, 1'b0, 4'b0011, 1'b0, 0, "stall_c2");
    step(1'b0, 1'b0, 4'b0011, 1'b0, 0, "stall_c3");
    step(1'b0, 1'b0, 4'b0011, 1'b1, 0, "stall_release");
    step(1'b0, 1'b0, 4'b0011, 1'b1, 1, "after_stall");

    // Burst forfeited on request drop, fresh credit on return (weight[0]=3).
    do_reset(16'h0003);
    step(1'b0, 1'b0, 4'b0011, 1'b1, 0, "burst_start");
    step(1'b0, 1'b0, 4'b0010, 1'b1, 1, "burst_drop");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0011, 1'b1, 0, "burst_fresh");
    step(1'b0, 1'b0, 4'b0011, 1'b1, 1, "burst_end");

    // Strict priority, then mode toggle while locked.
    do_reset(16'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1010, 1'b1, 1, "prio");
    step(1'b0, 1'b1, 4'b1010, 1'b0, 1, "prio_stall");
    step(1'b0, 1'b0, 4'b1010, 1'b0, 1, "mode_toggle_locked");
    step(1'b0, 1'b0, 4'b1010, 1'b1, 1, "lock_release");
    step(1'b0, 1'b0, 4'b1010, 1'b1, 3, "wrr_after_prio");

    // Reset pulse in the middle of a burst on port 2 (weight[2]=2).
    do_reset(16'h0200);
    step(1'b0, 1'b0, 4'b1111, 1'b1, 0, "pre_burst0");
    step(1'b0, 1'b0, 4'b1111, 1'b1, 1, "pre_burst1");
    step(1'b0, 1'b0, 4'b1111, 1'b1, 2, "burst_p2");
    step(1'b1, 1'b0, 4'b1111, 1'b1, 2, "rst_pulse");
    step(1'b0, 1'b0, 4'b1111, 1'b1, 0, "post_rst0");
    step(1'b0, 1'b0, 4'b1111, 1'b1, 1, "post_rst1");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prim_arbiter_wrr.md
Name: prim_arbiter_wrr

Overview:
- N:1 weighted round-robin arbiter with an optional strict-priority mode.
- Each port may win up to weight+1 consecutive grants (a burst) before arbitration moves to the next requester.
- Holds its decision while the sink stalls, as required by TL/AXI-style interconnects.
- Drop-in next generation of the single-grant round-robin arbiter, for crossbar/hub sinks that need bandwidth shaping.

Parameters:
- N, 8, number of request ports (N>=2; N==1 is a bypass).
- DW, 32, data width.
- WeightW, 4, bits per port weight; weight value w gives w+1 consecutive grants.
- EnDataPort, 1, 0 drives data_o to all ones and ignores data_i.
- IdxW, $clog2(N), index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_chk_i  in  1  assertion gating only, non-functional.
- mode_i  in  1  0 = weighted round-robin, 1 = strict priority (lowest index wins).
- weight_i  in  N*WeightW  per-port weight; port k uses bits [k*WeightW +: WeightW].
- req_i  in  N  requests.
- data_i  in  N x DW  per-port data (unpacked array [N]).
- gnt_o  out  N  one-hot grant.
- idx_o  out  IdxW  winner index.
- valid_o  out  1  any request present.
- data_o  out  DW  winner data.
- ready_i  in  1  sink ready.

Behaviour:
- Grant path is combinational, zero-cycle latency.
  - valid_o = |req_i.
  - gnt_o = ready_i ? winner : 0.
  - idx_o and data_o follow the winner; both are 0 when there is no request.
- State registers, all cleared to 0 by rst_i:
  - mask (N bits).
  - last_idx (IdxW).
  - cnt (WeightW): remaining extra grants for last_idx.
  - locked (1).
  - lock_idx (IdxW).
- rst_i is sampled at clk_i.
  - Asserting it mid-burst or mid-lock discards all state the following cycle.
  - Outputs stay combinational during reset.
- Winner priority, evaluated each cycle:
  1. locked && req_i[lock_idx]: winner = lock_idx.
  2. mode_i==0 && cnt!=0 && req_i[last_idx]: winner = last_idx (burst continues).
  3. mode_i==1: winner = lowest set bit of req_i.
  4. Otherwise round-robin:
     - Take the lowest set bit of (req_i & mask).
     - If that is empty, take the lowest set bit of req_i (wrap-around).
- Accepting cycle (valid_o && ready_i):
  - locked <= 0.
  - mask <= bits strictly above winner.
  - If winner==last_idx and rule 2 applied: cnt <= cnt-1.
  - Else: cnt <= weight_i[winner] (weight sampled only at burst start); last_idx <= winner.
- Stall cycle (valid_o && !ready_i): locked <= 1, lock_idx <= winner. mask and cnt are unchanged.
- Idle or request-drop cycle: if req_i[last_idx]==0 and there is no grant, cnt <= 0. A burst is forfeited, never resumed.
- Lock violation: req_i[lock_idx] drops while locked.
  - Arbitration falls through to rules 2-4 that cycle.
  - locked follows the normal update for that cycle.
  - Flagged by an assertion gated by req_chk_i.
- Mode change:
  - A change in mode_i is honoured only when not locked.
  - Switching to mode 1 leaves cnt untouched but ignores it.
  - Switching back resumes any unexpired burst if its requester is still present.
- Weight 0 on all ports degenerates to the plain round-robin order.
- Assertions:
  - gnt_o is onehot0.
  - gnt implies ready_i and req_i[idx_o].
  - idx_o is stable while stalled (|req_i && !ready_i).
  - No port is granted more than weight+1 times consecutively while another port requests (mode 0).
  - Outputs are known.

Decomposition:
- prim_arbiter_pkg holds:
  - arb_mode_e (ArbModeWrr=1'b0, ArbModePrio=1'b1).
  - A function returning the lowest-set-bit one-hot of a vector.
- Sub-module prim_arbiter_rr_pick: combinational pick of masked/unmasked leading one via parallel-prefix OR. Outputs one-hot and index. Instantiated once.
- The top level holds the credit, lock and mask registers and the data mux.

Test Plan:
- Reset, req_i=0 -> valid_o=0, gnt_o=0, idx_o=0, data_o=0; after rst_i falls, first req_i=4'b0100 with ready_i=1 -> gnt_o=4'b0100 the same cycle.
- N=4, weight[1]=2, others 0, req_i=4'b1111, ready_i=1 held -> idx_o sequence 0,1,1,1,2,3,0,1,1,1.
- req_i=4'b0001, ready_i=0 for 3 cycles, req_i[1] raised in cycle 2 -> idx_o=0 throughout; ready_i=1 -> grant port 0, next grant port 1.
- weight[0]=3, req_i=4'b0011: grant 0, then drop req_i[0] one cycle -> grant 1; re-raise req_i[0] -> port 0 wins 4 consecutive grants (fresh credit).
- mode_i=1, req_i=4'b1010, ready_i=1 -> gnt_o=4'b0010 every cycle; toggle mode_i while stalled -> winner unchanged until the grant completes.
- Pulse rst_i for one cycle mid-burst (cnt=2 on port 2, req_i=4'b1111) -> next cycle idx_o=0, cnt=0.
